// File: rtl/uart_pkg.sv
// Shared UART transmit-scheduler types and constants.
package uart_pkg;

    localparam int unsigned UART_BYTE_W = 8;
    localparam int unsigned UART_WORD_W = 32;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_FIRE,
        S_START,
        S_WAIT
    } txsched_state_t;

endpackage

// File: rtl/uart_txsched_arb.sv
// Requester arbiter for uart_tx_sched: combinational winner select.
// UART_TXSCHED_RR_EN defined: round-robin with a rotating start pointer;
// otherwise fixed priority (lowest index wins) and no pointer register.
module uart_txsched_arb
    import uart_pkg::*;
#(
    parameter  int unsigned NREQ  = 3,
    localparam int unsigned IDX_W = $clog2(NREQ)
) (
`ifdef UART_TXSCHED_RR_EN
    input  logic             clk,
    input  logic             rst_n,
    input  logic             adv,
`endif
    input  logic [NREQ-1:0]  req_valid,
    output logic             any_c,
    output logic [IDX_W-1:0] win_idx_c,
    output logic [NREQ-1:0]  win_oh_c
);

    logic [IDX_W-1:0] start_idx;

`ifdef UART_TXSCHED_RR_EN
    logic [IDX_W-1:0] rr_ptr_q;
    logic [IDX_W-1:0] rr_ptr_d;

    assign start_idx = rr_ptr_q;

    // Advance the pointer past the winner on each grant, wrapping NREQ-1 -> 0
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (adv) begin
            if (win_idx_c == IDX_W'(NREQ - 1)) begin
                rr_ptr_d = '0;
            end else begin
                rr_ptr_d = win_idx_c + IDX_W'(1);
            end
        end
    end

    // Pointer register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end
`else
    assign start_idx = '0;
`endif

    // First valid requester scanning upward from start_idx with wrap
    always_comb begin
        int unsigned idx;
        any_c     = 1'b0;
        win_idx_c = '0;
        win_oh_c  = '0;
        idx       = 0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            idx = 32'(start_idx) + i;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!any_c && req_valid[IDX_W'(idx)]) begin
                any_c     = 1'b1;
                win_idx_c = IDX_W'(idx);
            end
        end
        if (any_c) begin
            win_oh_c[win_idx_c] = 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_sched.sv
// Shares one UART transmitter among NREQ byte requesters: grant, load the
// transmit buffer, pulse trmt, then hold off until the UART reports done.
// Optional macro UART_TXSCHED_RR_EN selects round-robin arbitration.
module uart_tx_sched
    import uart_pkg::*;
#(
    parameter  int unsigned NREQ     = 3,
    parameter  int unsigned START_TO = 64,
    localparam int unsigned IDX_W    = $clog2(NREQ),
    localparam int unsigned TO_W     = (START_TO > 1) ? $clog2(START_TO) : 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NREQ-1:0]             req_valid,
    input  logic [UART_BYTE_W*NREQ-1:0] req_data,
    output logic [NREQ-1:0]             req_ready,
    output logic                        uart_data_we,
    output logic [UART_WORD_W-1:0]      uart_data_tx,
    output logic                        uart_trmt,
    input  logic                        uart_tx_done,
    output logic                        busy,
    output logic [IDX_W-1:0]            grant_id,
    output logic                        stall_err
);

    txsched_state_t         state_q, state_d;
    logic [UART_BYTE_W-1:0] byte_q, byte_d;
    logic [IDX_W-1:0]       grant_id_q, grant_id_d;
    logic                   stall_q, stall_d;
    logic [TO_W-1:0]        to_cnt_q, to_cnt_d;
    logic                   data_we_q, data_we_d;
    logic                   trmt_q, trmt_d;
    logic                   busy_q, busy_d;
    logic [NREQ-1:0]        req_ready_c;
    logic                   grant_c;

    logic                   any_c;
    logic [IDX_W-1:0]       win_idx_c;
    logic [NREQ-1:0]        win_oh_c;

    uart_txsched_arb #(
        .NREQ (NREQ)
    ) u_arb (
`ifdef UART_TXSCHED_RR_EN
        .clk       (clk),
        .rst_n     (rst_n),
        .adv       (grant_c),
`endif
        .req_valid (req_valid),
        .any_c     (any_c),
        .win_idx_c (win_idx_c),
        .win_oh_c  (win_oh_c)
    );

    // Next-state, capture and timeout logic; strobes are registered from state_d
    always_comb begin
        state_d     = state_q;
        byte_d      = byte_q;
        grant_id_d  = grant_id_q;
        stall_d     = stall_q;
        to_cnt_d    = to_cnt_q;
        req_ready_c = '0;
        grant_c     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (any_c) begin
                    req_ready_c = win_oh_c;
                    grant_c     = 1'b1;
                    grant_id_d  = win_idx_c;
                    for (int unsigned i = 0; i < NREQ; i++) begin
                        if (win_idx_c == IDX_W'(i)) begin
                            byte_d = req_data[i*UART_BYTE_W +: UART_BYTE_W];
                        end
                    end
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                state_d = S_FIRE;
            end
            S_FIRE: begin
                to_cnt_d = '0;
                state_d  = S_START;
            end
            S_START: begin
                // A leftover tx_done=1 from the previous frame is ignored until it falls
                if (!uart_tx_done) begin
                    state_d = S_WAIT;
                end else if (to_cnt_q == TO_W'(START_TO - 1)) begin
                    stall_d = 1'b1;
                    state_d = S_IDLE;
                end else if (to_cnt_q != '1) begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end
            S_WAIT: begin
                if (uart_tx_done) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        data_we_d = (state_d == S_LOAD);
        trmt_d    = (state_d == S_FIRE);
        busy_d    = (state_d != S_IDLE);
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            byte_q     <= '0;
            grant_id_q <= '0;
            stall_q    <= 1'b0;
            to_cnt_q   <= '0;
            data_we_q  <= 1'b0;
            trmt_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_q     <= byte_d;
            grant_id_q <= grant_id_d;
            stall_q    <= stall_d;
            to_cnt_q   <= to_cnt_d;
            data_we_q  <= data_we_d;
            trmt_q     <= trmt_d;
            busy_q     <= busy_d;
        end
    end

    assign req_ready    = req_ready_c;
    assign uart_data_we = data_we_q;
    assign uart_data_tx = {(UART_WORD_W - UART_BYTE_W)'(0), byte_q};
    assign uart_trmt    = trmt_q;
    assign busy         = busy_q;
    assign grant_id     = grant_id_q;
    assign stall_err    = stall_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched (NREQ=3 main instance, NREQ=2 wrap instance).
module tb_uart_tx_sched;

`ifdef UART_TXSCHED_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;

    logic [2:0]  req_valid = '0;
    logic [23:0] req_data  = '0;
    logic [2:0]  req_ready;
    logic        uart_data_we;
    logic [31:0] uart_data_tx;
    logic        uart_trmt;
    logic        uart_tx_done = 1'b1;
    logic        busy;
    logic [1:0]  grant_id;
    logic        stall_err;

    logic [1:0]  v2 = '0;
    logic [15:0] d2 = '0;
    logic [1:0]  ready2;
    logic        we2;
    logic [31:0] tx2;
    logic        trmt2;
    logic        done2 = 1'b1;
    logic        busy2;
    logic [0:0]  gid2;
    logic        stall2;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [2:0]  v;
        logic [23:0] d;
        logic [1:0]  id;
        logic [7:0]  b;
        int          stale;
    } vec_t;

    vec_t tbl [10];

    always #5 clk = ~clk;

    uart_tx_sched #(.NREQ(3), .START_TO(64)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .uart_data_we (uart_data_we),
        .uart_data_tx (uart_data_tx),
        .uart_trmt    (uart_trmt),
        .uart_tx_done (uart_tx_done),
        .busy         (busy),
        .grant_id     (grant_id),
        .stall_err    (stall_err)
    );

    uart_tx_sched #(.NREQ(2), .START_TO(64)) dut2 (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (v2),
        .req_data     (d2),
        .req_ready    (ready2),
        .uart_data_we (we2),
        .uart_data_tx (tx2),
        .uart_trmt    (trmt2),
        .uart_tx_done (done2),
        .busy         (busy2),
        .grant_id     (gid2),
        .stall_err    (stall2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // One full frame on the main instance; tx_done stays 1 for 'stale' START cycles
    task automatic run_txn(input logic [2:0] v, input logic [23:0] d,
                           input logic [1:0] id, input logic [7:0] b, input int stale);
        logic [2:0] oh;
        oh           = 3'b001 << id;
        req_valid    = v;
        req_data     = d;
        uart_tx_done = 1'b1;
        #1;
        chk("ready_onehot", 32'(req_ready), 32'(oh));
        chk("busy_idle", 32'(busy), 32'd0);
        step;
        chk("load_we", 32'(uart_data_we), 32'd1);
        chk("load_data", uart_data_tx, {24'h0, b});
        chk("grant_id", 32'(grant_id), 32'(id));
        chk("load_trmt", 32'(uart_trmt), 32'd0);
        chk("load_ready", 32'(req_ready), 32'd0);
        step;
        chk("fire_trmt", 32'(uart_trmt), 32'd1);
        chk("fire_we", 32'(uart_data_we), 32'd0);
        step;
        for (int i = 0; i < stale; i++) begin
            chk("start_trmt", 32'(uart_trmt), 32'd0);
            chk("start_busy", 32'(busy), 32'd1);
            chk("start_ready", 32'(req_ready), 32'd0);
            step;
        end
        uart_tx_done = 1'b0;
        step;
        chk("wait_busy", 32'(busy), 32'd1);
        chk("wait_ready", 32'(req_ready), 32'd0);
        step;
        chk("wait_busy2", 32'(busy), 32'd1);
        uart_tx_done = 1'b1;
        step;
        chk("done_busy", 32'(busy), 32'd0);
        chk("hold_data", uart_data_tx, {24'h0, b});
    endtask

    // One full frame on the NREQ=2 instance
    task automatic txn2(input logic [1:0] v, input logic [0:0] id, input logic [7:0] b);
        logic [1:0] oh;
        oh    = 2'b01 << id;
        v2    = v;
        d2    = 16'h5A3C;
        done2 = 1'b1;
        #1;
        chk("n2_ready", 32'(ready2), 32'(oh));
        step;
        v2 = '0;
        chk("n2_grant", 32'(gid2), 32'(id));
        chk("n2_we", 32'(we2), 32'd1);
        chk("n2_data", tx2, {24'h0, b});
        step;
        chk("n2_trmt", 32'(trmt2), 32'd1);
        step;
        done2 = 1'b0;
        step;
        done2 = 1'b1;
        step;
        chk("n2_busy", 32'(busy2), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{3'b010, 24'hC3A55A, 2'd1, 8'hA5, 0};
        tbl[1] = '{3'b111, 24'h332211, RR ? 2'd2 : 2'd0, RR ? 8'h33 : 8'h11, 0};
        tbl[2] = '{3'b111, 24'h332211, 2'd0, 8'h11, 0};
        tbl[3] = '{3'b111, 24'h332211, RR ? 2'd1 : 2'd0, RR ? 8'h22 : 8'h11, 2};
        tbl[4] = '{3'b111, 24'h332211, RR ? 2'd2 : 2'd0, RR ? 8'h33 : 8'h11, 0};
        tbl[5] = '{3'b111, 24'h332211, 2'd0, 8'h11, 0};
        tbl[6] = '{3'b111, 24'h332211, RR ? 2'd1 : 2'd0, RR ? 8'h22 : 8'h11, 0};
        tbl[7] = '{3'b100, 24'h332211, 2'd2, 8'h33, 0};
        tbl[8] = '{3'b001, 24'h332211, 2'd0, 8'h11, 0};
        tbl[9] = '{3'b101, 24'h332211, RR ? 2'd2 : 2'd0, RR ? 8'h33 : 8'h11, 5};

        // Reset state
        #12;
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_we", 32'(uart_data_we), 32'd0);
        chk("rst_data", uart_data_tx, 32'd0);
        chk("rst_trmt", 32'(uart_trmt), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_gid", 32'(grant_id), 32'd0);
        chk("rst_stall", 32'(stall_err), 32'd0);
        step;
        rst_n = 1'b1;
        step;

        for (int k = 0; k < 10; k++) begin
            run_txn(tbl[k].v, tbl[k].d, tbl[k].id, tbl[k].b, tbl[k].stale);
        end

        // Start timeout: tx_done stuck high through START
        req_valid    = 3'b001;
        req_data     = 24'h0000EE;
        uart_tx_done = 1'b1;
        #1;
        step;
        req_valid = '0;
        step;
        chk("to_trmt", 32'(uart_trmt), 32'd1);
        step;
        for (int i = 0; i < 64; i++) begin
            chk("to_stall_low", 32'(stall_err), 32'd0);
            chk("to_busy", 32'(busy), 32'd1);
            step;
        end
        chk("to_stall_set", 32'(stall_err), 32'd1);
        chk("to_idle", 32'(busy), 32'd0);
        run_txn(3'b010, 24'hC3A55A, 2'd1, 8'hA5, 0);
        chk("to_sticky", 32'(stall_err), 32'd1);

        // Reset while in WAIT
        req_valid    = 3'b100;
        req_data     = 24'h7E0000;
        uart_tx_done = 1'b1;
        #1;
        step;
        req_valid = '0;
        step;
        step;
        uart_tx_done = 1'b0;
        step;
        chk("w_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mr_busy", 32'(busy), 32'd0);
        chk("mr_data", uart_data_tx, 32'd0);
        chk("mr_gid", 32'(grant_id), 32'd0);
        chk("mr_stall", 32'(stall_err), 32'd0);
        chk("mr_ready", 32'(req_ready), 32'd0);
        uart_tx_done = 1'b1;
        step;
        rst_n = 1'b1;
        run_txn(3'b100, 24'h7E0000, 2'd2, 8'h7E, 0);

        // NREQ=2 wrap: pointer reaches 1, only req 0 valid
        txn2(2'b01, 1'b0, 8'h3C);
        txn2(2'b01, 1'b0, 8'h3C);
        txn2(2'b11, RR ? 1'b1 : 1'b0, RR ? 8'h5A : 8'h3C);
        chk("n2_stall", 32'(stall2), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
